// File: rtl/lumi_pkg.sv
// Shared constants and types for the LUMI transmit arbiter.
package lumi_pkg;

  localparam int UMI_EOM_BIT = 22;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOCK_REQ  = 2'd1,
    LOCK_RESP = 2'd2
  } state_t;

  localparam logic SRC_REQ  = 1'b0;
  localparam logic SRC_RESP = 1'b1;

endpackage

// File: rtl/umi_pipe_reg.sv
// One-entry valid/ready register; loads on the same edge it drains, so one beat per cycle.
module umi_pipe_reg #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          load_i,
  input  logic [PW-1:0] payload_i,
  output logic          space_o,
  output logic          valid_o,
  output logic [PW-1:0] payload_o,
  input  logic          ready_i
);

  logic          valid_q;
  logic [PW-1:0] payload_q;

  assign space_o   = ~valid_q | ready_i;
  assign valid_o   = valid_q;
  assign payload_o = payload_q;

  // Any held beat is discarded on reset, including one stalled by the serializer.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else if (load_i) begin
      valid_q   <= 1'b1;
      payload_q <= payload_i;
    end else if (ready_i) begin
      valid_q   <= 1'b0;
    end
  end

endmodule

// File: rtl/lumi_tx_arb.sv
// Request/response arbiter feeding the LUMI TX serializer; packets stay atomic until EOM.
module lumi_tx_arb
  import lumi_pkg::*;
#(
  parameter int DW = 128,
  parameter int CW = 32,
  parameter int AW = 64
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          csr_en,
  input  logic          csr_resp_prio,
  input  logic          umi_req_in_valid,
  input  logic [CW-1:0] umi_req_in_cmd,
  input  logic [AW-1:0] umi_req_in_dstaddr,
  input  logic [AW-1:0] umi_req_in_srcaddr,
  input  logic [DW-1:0] umi_req_in_data,
  output logic          umi_req_in_ready,
  input  logic          umi_resp_in_valid,
  input  logic [CW-1:0] umi_resp_in_cmd,
  input  logic [AW-1:0] umi_resp_in_dstaddr,
  input  logic [AW-1:0] umi_resp_in_srcaddr,
  input  logic [DW-1:0] umi_resp_in_data,
  output logic          umi_resp_in_ready,
  output logic          umi_out_valid,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data,
  output logic          umi_out_src,
  input  logic          umi_out_ready
);

  localparam int PW = 1 + CW + 2*AW + DW;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          grant_req, grant_resp;
  logic          space;
  logic          accept;
  logic          sel_eom;
  logic [PW-1:0] sel_payload;

  always_comb begin
    grant_req    = 1'b0;
    grant_resp   = 1'b0;
    state_d      = state_q;
    last_grant_d = last_grant_q;

    case (state_q)
      IDLE: begin
        // Ties go to the channel that did not finish the previous packet, unless response has priority.
        if (csr_en) begin
          if (umi_req_in_valid && umi_resp_in_valid) begin
            if (csr_resp_prio || (last_grant_q == SRC_REQ)) grant_resp = 1'b1;
            else                                             grant_req  = 1'b1;
          end else if (umi_req_in_valid) begin
            grant_req = 1'b1;
          end else if (umi_resp_in_valid) begin
            grant_resp = 1'b1;
          end
        end
      end
      LOCK_REQ:  grant_req  = 1'b1;
      LOCK_RESP: grant_resp = 1'b1;
      default:   ;
    endcase

    if (accept) begin
      if (sel_eom) begin
        state_d      = IDLE;
        last_grant_d = grant_resp ? SRC_RESP : SRC_REQ;
      end else begin
        state_d      = grant_resp ? LOCK_RESP : LOCK_REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_RESP;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // nreset term keeps both readies low while reset is held.
  assign umi_req_in_ready  = grant_req  & space & nreset;
  assign umi_resp_in_ready = grant_resp & space & nreset;
  assign accept = (umi_req_in_valid & umi_req_in_ready) | (umi_resp_in_valid & umi_resp_in_ready);

  assign sel_eom     = grant_resp ? umi_resp_in_cmd[UMI_EOM_BIT] : umi_req_in_cmd[UMI_EOM_BIT];
  assign sel_payload = grant_resp ?
    {SRC_RESP, umi_resp_in_cmd, umi_resp_in_dstaddr, umi_resp_in_srcaddr, umi_resp_in_data} :
    {SRC_REQ,  umi_req_in_cmd,  umi_req_in_dstaddr,  umi_req_in_srcaddr,  umi_req_in_data};

  umi_pipe_reg #(.PW(PW)) u_out_reg (
    .clk       (clk),
    .nreset    (nreset),
    .load_i    (accept),
    .payload_i (sel_payload),
    .space_o   (space),
    .valid_o   (umi_out_valid),
    .payload_o ({umi_out_src, umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data}),
    .ready_i   (umi_out_ready)
  );

endmodule

// File: doc/lumi_tx_arb.md
Name: lumi_tx_arb

Overview:
- Arbiter and scheduler placed in front of the LUMI transmit serializer.
- Shares one serializer input between the UMI request channel and the UMI response channel.
- Multi-beat transactions stay atomic: the grant holds until the EOM beat.
- Fair round-robin or strict response priority, selected by CSR.
- Output is registered (one-entry pipeline stage) so the serializer sees a clean valid/ready source.

Parameters:
- DW, 128, UMI data width
- CW, 32, UMI command width
- AW, 64, UMI address width

Ports:
- clk  input  1  core clock
- nreset  input  1  asynchronous active-low reset
- csr_en  input  1  enables starting new transactions
- csr_resp_prio  input  1  1 = response wins ties (strict priority); 0 = round-robin
- umi_req_in_valid  input  1  request channel valid
- umi_req_in_cmd  input  CW  request command
- umi_req_in_dstaddr  input  AW  request destination address
- umi_req_in_srcaddr  input  AW  request source address
- umi_req_in_data  input  DW  request data
- umi_req_in_ready  output  1  request channel ready
- umi_resp_in_valid/cmd/dstaddr/srcaddr/data  input  1/CW/AW/AW/DW  response channel, same meaning as request
- umi_resp_in_ready  output  1  response channel ready
- umi_out_valid  output  1  to serializer
- umi_out_cmd  output  CW  to serializer
- umi_out_dstaddr  output  AW  to serializer
- umi_out_srcaddr  output  AW  to serializer
- umi_out_data  output  DW  to serializer
- umi_out_src  output  1  source of the held beat: 0 = request, 1 = response
- umi_out_ready  input  1  from serializer

Behaviour:
- Reset (async, nreset=0):
  - state=IDLE, last_grant=resp (so request wins the first tie).
  - umi_out_valid=0; umi_out_cmd/dstaddr/srcaddr/data/src=0.
  - Both input readies=0.
- EOM is cmd[UMI_EOM_BIT] = bit 22.
- Output stage: space = ~umi_out_valid | umi_out_ready.
  - A beat accepted on an input loads the output register on the same edge; umi_out_valid=1 the next cycle (latency 1).
  - Out-handshake without a new accept clears umi_out_valid.
  - Simultaneous out-handshake and accept: register reloads, valid stays 1.
  - Full throughput is one beat per cycle.
- Ready: umi_X_in_ready = grant_X & space. The grant is combinational from state, valids, last_grant, csr_en and csr_resp_prio. Ready never depends on the same channel's valid except through the IDLE grant choice.
- FSM states: IDLE, LOCK_REQ, LOCK_RESP.
- IDLE:
  - Grants only if csr_en=1.
  - One valid: grant it.
  - Both valid: if csr_resp_prio, grant resp; otherwise grant the channel != last_grant.
  - On accept with EOM=0: go to LOCK_X.
  - On accept with EOM=1: stay in IDLE.
  - Every accepted EOM beat sets last_grant=X.
- LOCK_X:
  - Grant X only, regardless of csr_en or the other channel.
  - On accept of the EOM beat: go to IDLE, last_grant=X.
  - A LOCK_X with valid low holds the lock (no switch mid-transaction).
- Disable: csr_en falling mid-transaction does not stall the locked transaction. Only new starts are blocked. The output register always drains.
- Data integrity: input fields are copied unmodified; umi_out_src records the granted channel.
- Reset mid-transaction: everything returns to reset values immediately; any partial beat in the output register is discarded.
- Backpressure: while umi_out_valid=1 and umi_out_ready=0, the output fields are stable.

Decomposition:
- Package lumi_pkg: UMI_EOM_BIT=22, state enum {IDLE, LOCK_REQ, LOCK_RESP}, source encoding constants SRC_REQ=0 and SRC_RESP=1.
- Sub-module umi_pipe_reg: one-entry valid/ready register, parameterized on total payload width. Holds {src, cmd, dstaddr, srcaddr, data}.
- The arbiter FSM lives in the top module.

Test Plan:
- Single channel, csr_en=1, csr_resp_prio=0, umi_out_ready=1: request beats A1(EOM=1), A2(EOM=1) -> output A1 at cycle+1, then A2; umi_out_src=0; req_ready stays 1.
- Both valid, single-beat packets, round-robin -> out order req, resp, req, resp; umi_out_src alternates 0,1,0,1 starting with 0 after reset.
- Request 3-beat packet (EOM only on beat 3), response valid throughout, req valid dropped for 2 cycles after beat 1 -> resp_ready=0 until req beat 3 accepted; response beat emitted right after req beat 3.
- csr_resp_prio=1, both continuously valid with single-beat packets -> all output beats are response; req_ready=0 throughout.
- umi_out_ready held 0 for 5 cycles with out valid -> output fields stable; both input readies=0; resume yields no loss or duplication.
- csr_en drops during beat 2 of a 4-beat resp packet -> beats 3 and 4 still pass; no new packet starts until csr_en=1.
- nreset asserted mid-packet -> umi_out_valid=0 asynchronously; after release, state=IDLE and request wins the first tie.
